uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sampler.sv | 58 +++++
 rtl/uart_rx_param.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_mode_t;

  localparam int MIN_CLKS_PER_BIT = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rxd synchroniser, bit-period counter and 3-sample majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  input  logic restart,
  output logic rxs,
  output logic bit_value,
  output logic bit_strobe,
  output logic end_of_bit
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HM1  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_HP1  = CW'(HALF + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   s0_q, s1_q;

  // Idle line is high, so the chain resets to 1 to avoid a spurious start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || cnt_q == CNT_LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == CNT_HM1)  s0_q <= rxs;
      if (cnt_q == CNT_HALF) s1_q <= rxs;
    end
  end

  // Third sample is taken live, so the vote resolves at HALF+1.
  assign bit_value  = maj3(s0_q, s1_q, rxs);
  assign bit_strobe = (cnt_q == CNT_HP1);
  assign end_of_bit = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: framing FSM, error checks, valid/ready
// holding register and frame/error counters.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic [31:0]          frame_count,
  output logic [31:0]          error_count
);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic STOP_LAST  = (STOP_BITS == 2);
  localparam bit   HAS_PARITY = (PARITY_MODE != int'(PAR_NONE));
  localparam logic ODD_PARITY = (PARITY_MODE == int'(PAR_ODD));

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_clks_check
    $error("uart_rx_param: CLKS_PER_BIT must be >= %0d", MIN_CLKS_PER_BIT);
  end

  logic rxs, bit_value, bit_strobe, end_of_bit, restart;

  rx_state_t            state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 deliver;

  logic                 valid_q, hperr_q, hferr_q, ovr_q;
  logic [DATA_BITS-1:0] data_q;
  logic [31:0]          fcnt_q, ecnt_q;

  // Counter is held at zero while waiting so the start bit is timed from its edge.
  assign restart = (state_q == IDLE) || (state_q == WAIT_IDLE);

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .restart   (restart),
    .rxs       (rxs),
    .bit_value (bit_value),
    .bit_strobe(bit_strobe),
    .end_of_bit(end_of_bit)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    deliver    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (bit_strobe && bit_value) begin
          state_d = IDLE;
        end else if (end_of_bit) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_strobe) shift_d[idx_q] = bit_value;
        if (end_of_bit) begin
          if (idx_q == IDX_LAST) begin
            state_d    = HAS_PARITY ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_strobe) perr_d = ((^shift_q) ^ bit_value) != ODD_PARITY;
        if (end_of_bit) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_strobe) begin
          if (!bit_value) ferr_d = 1'b1;
          if (stop_idx_q == STOP_LAST) begin
            deliver = 1'b1;
            state_d = (ferr_q || !bit_value) ? WAIT_IDLE : IDLE;
          end
        end else if (end_of_bit) begin
          stop_idx_d = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // ferr_d already folds in the stop sample taken on the delivery cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      hperr_q <= 1'b0;
      hferr_q <= 1'b0;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      if (deliver) begin
        fcnt_q <= fcnt_q + 32'd1;
        if (perr_q || ferr_d) ecnt_q <= ecnt_q + 32'd1;
        if (!valid_q || rx_ready) begin
          valid_q <= 1'b1;
          data_q  <= shift_q;
          hperr_q <= perr_q;
          hferr_q <= ferr_d;
          if (valid_q) ovr_q <= 1'b0;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign rx_valid      = valid_q;
  assign rx_data       = data_q;
  assign rx_parity_err = hperr_q;
  assign rx_frame_err  = hferr_q;
  assign rx_overrun    = ovr_q;
  assign frame_count   = fcnt_q;
  assign error_count   = ecnt_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench for uart_rx_param (8 data bits, even parity, 2 stop bits).
module tb_uart_rx_param;
  localparam int CLKS = 16;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b1;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_parity_err, rx_frame_err, rx_overrun;
  logic [31:0]   frame_count, error_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_frames = 0;
  int exp_errs = 0;
  logic [DW+1:0] got_q[$];

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLKS_PER_BIT(CLKS),
    .DATA_BITS   (DW),
    .PARITY_MODE (2),
    .STOP_BITS   (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .rx_ready     (rx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .frame_count  (frame_count),
    .error_count  (error_count)
  );

  // Every accepted word (valid && ready) is captured as {perr, ferr, data}.
  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready)
      got_q.push_back({rx_parity_err, rx_frame_err, rx_data});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic hold_bit(input logic v, input int glitch_off);
    for (int c = 0; c < CLKS; c++) begin
      @(posedge clk); #1;
      rxd = (c == glitch_off) ? ~v : v;
    end
  endtask

  task automatic idle_bits(input int n);
    for (int b = 0; b < n; b++) hold_bit(1'b1, -1);
  endtask

  // Frame: start, 8 data LSB first, even parity (optionally inverted), 2 stop bits.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic [1:0] stops,
                            input int glitch_bit, input int abort_bit);
    hold_bit(1'b0, -1);
    for (int i = 0; i < DW; i++) begin
      if (i == abort_bit) begin
        for (int c = 0; c < CLKS / 2; c++) begin
          @(posedge clk); #1;
          rxd = d[i];
        end
        @(posedge clk); #1;
        reset = 1'b1;
        rxd   = 1'b1;
        return;
      end
      hold_bit(d[i], (i == glitch_bit) ? int'($urandom_range(2, 14)) : -1);
    end
    hold_bit((^d) ^ bad_par, -1);
    hold_bit(stops[0], -1);
    hold_bit(stops[1], -1);
    rxd = 1'b1;
  endtask

  // Reference: expected word and counters from the frame contents alone.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic bad_par,
                             input logic [1:0] stops);
    logic        ferr;
    logic [DW+1:0] w;
    int          waited;
    ferr = (stops != 2'b11);
    exp_frames++;
    if (bad_par || ferr) exp_errs++;
    waited = 0;
    while (got_q.size() == 0 && waited < 4 * CLKS) begin
      @(posedge clk); #1;
      waited++;
    end
    check_val({tag, "_seen"}, 32'(got_q.size() != 0), 32'd1);
    if (got_q.size() != 0) begin
      w = got_q.pop_front();
      check_val({tag, "_data"}, 32'(w[DW-1:0]), 32'(d));
      check_val({tag, "_perr"}, 32'(w[DW+1]), 32'(bad_par));
      check_val({tag, "_ferr"}, 32'(w[DW]), 32'(ferr));
    end
    check_val({tag, "_fcnt"}, frame_count, 32'(exp_frames));
    check_val({tag, "_ecnt"}, error_count, 32'(exp_errs));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check_val({tag, "_data"}, 32'(rx_data), 32'd0);
    check_val({tag, "_errs"}, 32'({rx_parity_err, rx_frame_err, rx_overrun}), 32'd0);
    check_val({tag, "_fcnt"}, frame_count, 32'd0);
    check_val({tag, "_ecnt"}, error_count, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       bp;
    logic [1:0] st;
    int         gb;

    repeat (4) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    idle_bits(2);

    send_frame(8'hA5, 1'b0, 2'b11, -1, -1);
    check_frame("a5", 8'hA5, 1'b0, 2'b11);
    idle_bits(1);

    send_frame(8'h03, 1'b1, 2'b11, -1, -1);
    check_frame("par_bad", 8'h03, 1'b1, 2'b11);
    idle_bits(1);
    send_frame(8'h03, 1'b0, 2'b11, -1, -1);
    check_frame("par_ok", 8'h03, 1'b0, 2'b11);
    idle_bits(1);

    // Short low pulse must be rejected as a false start.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      rxd = 1'b0;
    end
    @(posedge clk); #1;
    rxd = 1'b1;
    idle_bits(3);
    check_val("fstart_none", 32'(got_q.size()), 32'd0);
    check_val("fstart_fcnt", frame_count, 32'(exp_frames));

    send_frame(8'h00, 1'b0, 2'b11, 3, -1);
    check_frame("glitch", 8'h00, 1'b0, 2'b11);
    idle_bits(1);

    // Line break: stop bits low then held low; exactly one frame.
    send_frame(8'hC3, 1'b0, 2'b00, -1, -1);
    rxd = 1'b0;
    for (int b = 0; b < 5; b++) hold_bit(1'b0, -1);
    rxd = 1'b1;
    check_frame("brk", 8'hC3, 1'b0, 2'b00);
    idle_bits(2);
    check_val("brk_once", frame_count, 32'(exp_frames));
    check_val("brk_noextra", 32'(got_q.size()), 32'd0);
    send_frame(8'h5A, 1'b0, 2'b11, -1, -1);
    check_frame("after_brk", 8'h5A, 1'b0, 2'b11);
    idle_bits(1);

    // Overrun: second frame dropped while the first is held.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 2'b11, -1, -1);
    idle_bits(1);
    send_frame(8'h22, 1'b0, 2'b11, -1, -1);
    idle_bits(1);
    exp_frames += 2;
    check_val("ovr_valid", 32'(rx_valid), 32'd1);
    check_val("ovr_data", 32'(rx_data), 32'h11);
    check_val("ovr_flag", 32'(rx_overrun), 32'd1);
    check_val("ovr_fcnt", frame_count, 32'(exp_frames));
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    check_val("acc_valid", 32'(rx_valid), 32'd0);
    check_val("acc_ovr", 32'(rx_overrun), 32'd0);
    check_val("acc_word", 32'(got_q.size() == 1 ? got_q[0] : 10'h3FF), 32'h011);
    got_q.delete();

    // Reset mid data bit 4 while a word is held.
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b0, 2'b11, -1, -1);
    idle_bits(1);
    check_val("pre_rst_valid", 32'(rx_valid), 32'd1);
    send_frame(8'h3C, 1'b0, 2'b11, -1, 4);
    #1;
    check_idle_outputs("midrst");
    exp_frames = 0;
    exp_errs   = 0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_ready = 1'b1;
    idle_bits(2);
    send_frame(8'h3C, 1'b0, 2'b11, -1, -1);
    check_frame("post_rst", 8'h3C, 1'b0, 2'b11);
    idle_bits(1);

    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      st = 2'b11;
      if ($urandom_range(0, 5) == 0) st = 2'($urandom_range(0, 2));
      gb = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : -1;
      send_frame(d, bp, st, gb, -1);
      check_frame($sformatf("rnd%0d", n), d, bp, st);
      idle_bits(int'($urandom_range(1, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
